// File: rtl/ultrasonido_medidor.sv
// Ultrasonic range measurement: fires a TRIGGER pulse, waits for the ECHO rising
// edge and reports the ECHO high time in clock cycles with a one-cycle valid strobe.
module ultrasonido_medidor #(
    parameter int unsigned TRIG_CYCLES = 10,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned W           = 8
) (
    input  logic         CLKOUT,
    input  logic         reset,
    input  logic         start,
    input  logic         ECHO,
    output logic         TRIGGER,
    output logic         busy,
    output logic [W-1:0] cantidad,
    output logic         valid,
    output logic         timeout,
    output logic         overflow
);

    localparam int unsigned CW_TO  = $clog2(TIMEOUT + 1);
    localparam int unsigned CW_TR  = $clog2(TRIG_CYCLES + 1);
    localparam int unsigned CW_A   = (W > CW_TO) ? W : CW_TO;
    localparam int unsigned CW     = (CW_A > CW_TR) ? CW_A : CW_TR;

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'({W{1'b1}});

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_TRIG      = 2'd1;
    localparam logic [1:0] ST_WAIT_RISE = 2'd2;
    localparam logic [1:0] ST_MEASURE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sync_q, sync_d;
    logic [W-1:0]  cantidad_q, cantidad_d;
    logic          trigger_q, trigger_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic          overflow_q, overflow_d;

    logic echo_lvl;
    logic echo_rise;

    // Two flops resynchronise ECHO; the third only serves edge detection.
    assign sync_d    = {sync_q[1:0], ECHO};
    assign echo_lvl  = sync_q[1];
    assign echo_rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cantidad_d = cantidad_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;
        overflow_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_TRIG;
                    cnt_d   = '0;
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_RISE: begin
                // A rise in the last allowed cycle still wins over the timeout.
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CW'(1);
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_MEASURE: begin
                if (!echo_lvl) begin
                    state_d    = ST_IDLE;
                    cantidad_d = W'(cnt_q);
                    valid_d    = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d    = ST_IDLE;
                    cantidad_d = '1;
                    valid_d    = 1'b1;
                    overflow_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        trigger_d = (state_d == ST_TRIG);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLKOUT) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sync_q     <= '0;
            cantidad_q <= '0;
            trigger_q  <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_q     <= sync_d;
            cantidad_q <= cantidad_d;
            trigger_q  <= trigger_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign TRIGGER  = trigger_q;
    assign busy     = busy_q;
    assign cantidad = cantidad_q;
    assign valid    = valid_q;
    assign timeout  = timeout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ultrasonido_medidor.sv
// Bench for ultrasonido_medidor: each measurement is predicted from its echo delay and
// width, and every cycle of the transaction is compared against that prediction.
module tb_ultrasonido_medidor;

    logic       CLKOUT = 1'b0;
    logic       reset;
    logic       start;
    logic       ECHO;
    logic       TRIGGER;
    logic       busy;
    logic [7:0] cantidad;
    logic       valid;
    logic       timeout;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int last_cant = 0;

    localparam int TRIG_N  = 10;
    localparam int TO_N    = 255;
    localparam int MAX_CNT = 255;

    ultrasonido_medidor dut (
        .CLKOUT   (CLKOUT),
        .reset    (reset),
        .start    (start),
        .ECHO     (ECHO),
        .TRIGGER  (TRIGGER),
        .busy     (busy),
        .cantidad (cantidad),
        .valid    (valid),
        .timeout  (timeout),
        .overflow (overflow)
    );

    always #5 CLKOUT = ~CLKOUT;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag, input int exp_cant);
        chk({tag, "_trigger"},  32'(TRIGGER),  32'(0));
        chk({tag, "_busy"},     32'(busy),     32'(0));
        chk({tag, "_valid"},    32'(valid),    32'(0));
        chk({tag, "_timeout"},  32'(timeout),  32'(0));
        chk({tag, "_overflow"}, 32'(overflow), 32'(0));
        chk({tag, "_cantidad"}, 32'(cantidad), 32'(exp_cant));
    endtask

    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLKOUT);
            chk_quiet("idle", last_cant);
        end
    endtask

    // Called at a negedge with the DUT idle; raises start for the coming edge.
    // Cycle k is the k-th cycle after the edge that accepts start. ECHO is high for
    // the n cycles whose closing edges follow the TRIGGER fall edge by d+1 .. d+n.
    task automatic meas(input int d, input int n, input bit stuck, input bit noisy, input int rst_k);
        bit to;
        int exp_c;
        int end_k;
        int stop_k;
        to     = stuck || (n == 0);
        exp_c  = (n > MAX_CNT) ? MAX_CNT : n;
        end_k  = to ? (TRIG_N + TO_N + 1) : (TRIG_N + 4 + d + exp_c);
        stop_k = (rst_k > 0) ? rst_k + 1 : end_k;
        start  = 1'b1;
        ECHO   = stuck;
        for (int k = 1; k <= stop_k; k++) begin
            @(negedge CLKOUT);
            if (rst_k > 0 && k == rst_k + 1) begin
                reset     = 1'b0;
                last_cant = 0;
                chk_quiet("after_reset", 0);
            end else begin
                chk("trigger",  32'(TRIGGER),  32'(k <= TRIG_N));
                chk("busy",     32'(busy),     32'(k < end_k));
                chk("valid",    32'(valid),    32'(k == end_k && !to));
                chk("timeout",  32'(timeout),  32'(k == end_k && to));
                chk("overflow", 32'(overflow), 32'(k == end_k && n > MAX_CNT));
                if (k == end_k && !to) last_cant = exp_c;
                chk("cantidad", 32'(cantidad), 32'(last_cant));
            end
            ECHO  = stuck ? (k < end_k) : ((k >= TRIG_N + 1 + d) && (k <= TRIG_N + d + n));
            start = (noisy && k < stop_k) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rst_k > 0 && k == rst_k) reset = 1'b1;
        end
        ECHO = 1'b0;
    endtask

    initial begin
        int d;
        int n;
        bit nz;
        bit b2b;
        reset = 1'b1;
        start = 1'b0;
        ECHO  = 1'b0;
        repeat (3) @(negedge CLKOUT);
        chk_quiet("reset", 0);
        reset = 1'b0;
        idle_chk(2);

        // Basic measurement, echo 40 cycles starting 5 cycles after TRIGGER falls
        meas(4, 40, 1'b0, 1'b0, 0);
        idle_chk(2);
        meas(3, 25, 1'b0, 1'b0, 0);
        idle_chk(2);

        // No echo: timeout keeps the previous result
        meas(0, 0, 1'b0, 1'b0, 0);
        idle_chk(2);

        // Echo stuck high before and during the wait is not a rise
        ECHO = 1'b1;
        idle_chk(3);
        meas(0, 0, 1'b1, 1'b0, 0);
        idle_chk(3);

        // Saturation and the values around it
        meas(4, 300, 1'b0, 1'b0, 0);
        idle_chk(2);
        meas(2, 255, 1'b0, 1'b0, 0);
        idle_chk(2);
        meas(2, 254, 1'b0, 1'b0, 0);
        idle_chk(2);
        meas(1, 256, 1'b0, 1'b0, 0);
        idle_chk(2);

        // Latest possible rise, shortest echo
        meas(TO_N - 3, 7, 1'b0, 1'b0, 0);
        idle_chk(2);
        meas(0, 1, 1'b0, 1'b0, 0);
        idle_chk(2);

        // Start toggling while busy is ignored
        for (int i = 0; i < 4; i++) begin
            meas(int'($urandom_range(0, 40)), int'($urandom_range(1, 60)), 1'b0, 1'b1, 0);
            idle_chk(1);
        end
        meas(0, 0, 1'b0, 1'b1, 0);
        idle_chk(1);

        // Start held high: back-to-back measurements
        meas(3, 10, 1'b0, 1'b0, 0);
        meas(6, 15, 1'b0, 1'b0, 0);
        meas(0, 0, 1'b0, 1'b0, 0);
        meas(1, 9, 1'b0, 1'b0, 0);
        idle_chk(2);

        // Reset in the 20th MEASURE cycle, then a clean 12-cycle measurement
        meas(5, 60, 1'b0, 1'b0, TRIG_N + 3 + 5 + 20);
        idle_chk(3);
        meas(4, 12, 1'b0, 1'b0, 0);
        idle_chk(2);

        // Random mix
        for (int i = 0; i < 10; i++) begin
            d   = int'($urandom_range(0, 80));
            n   = int'($urandom_range(0, 120));
            nz  = 1'($urandom_range(0, 1));
            b2b = 1'($urandom_range(0, 1));
            meas(d, n, 1'b0, nz, 0);
            if (!b2b) idle_chk(int'($urandom_range(1, 4)));
        end
        idle_chk(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ultrasonido_medidor.md
# ultrasonido_medidor

Measures the pulse width of an ultrasonic sensor ECHO line and reports it as a cycle count. On a `start` request the block issues a TRIGGER pulse, waits for the ECHO rising edge, counts the cycles ECHO stays high, and publishes the count with a one-cycle `valid` strobe. It sits directly downstream of the echo generator (simulated sensor) or the physical sensor pin, and feeds distance-conversion and display logic.

## Interface
- `TRIG_CYCLES`, 10: TRIGGER high time in clock cycles (≥1).
- `TIMEOUT`, 255: maximum cycles to wait for an ECHO rising edge after TRIGGER ends (≥1).
- `W`, 8: width of the measured count.
- `CLKOUT` in 1: the single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: measurement request, sampled only in IDLE.
- `ECHO` in 1: echo input, possibly asynchronous; passes through a 2-flop synchronizer.
- `TRIGGER` out 1: trigger pulse to the sensor.
- `busy` out 1: high in every state except IDLE.
- `cantidad` out W: last measured ECHO high time in cycles; holds until the next valid.
- `valid` out 1: one-cycle strobe, `cantidad` updated.
- `timeout` out 1: one-cycle strobe, no echo within TIMEOUT.
- `overflow` out 1: one-cycle strobe with `valid` when the count saturated.

## Operation
- Synchronizer: `s1 <= ECHO; s2 <= s1; s3 <= s2`. Rise is `s2 & ~s3`. Level is `s2`.
- States: IDLE, TRIG, WAIT_RISE, MEASURE.
- IDLE: if `start`, go to TRIG, clear the counter, and set TRIGGER=1.
- TRIG: TRIGGER=1 for exactly TRIG_CYCLES cycles, then TRIGGER=0, go to WAIT_RISE, clear the counter.
- WAIT_RISE: the counter increments each cycle.
  - On rise: go to MEASURE, counter=1.
  - Else, if the counter reaches TIMEOUT: pulse `timeout`, go to IDLE. `cantidad` is unchanged.
  - An ECHO already high when WAIT_RISE is entered is not a rise. It must fall and rise again; that wait counts toward TIMEOUT.
- MEASURE:
  - While `s2`=1 and counter < 2^W−1: counter+1.
  - When `s2`=0: `cantidad` <= counter, pulse `valid`, go to IDLE.
  - When `s2`=1 and counter = 2^W−1: `cantidad` <= 2^W−1, pulse `valid` and `overflow` together, go to IDLE. The rest of the echo is ignored.
- Result: an ECHO held high for N consecutive sampled cycles yields `cantidad`=N (N < 2^W−1).
- `start` outside IDLE is ignored and not queued.
- Counter width is max(W, clog2(TIMEOUT+1), clog2(TRIG_CYCLES+1)) bits. No wrap-around is permitted.

## Timing
- Reset values: TRIGGER=0, busy=0, valid=0, timeout=0, overflow=0, cantidad=0, synchronizer flops=0, state IDLE.
- `reset` mid-operation: on the next edge the state returns to IDLE, TRIGGER drops, and all strobes are cleared. `cantidad` is cleared to 0 and a partial measurement is discarded.
- `start` sampled high at edge t:
  - TRIGGER and busy are high from after edge t through edge t+TRIG_CYCLES.
  - WAIT_RISE begins after edge t+TRIG_CYCLES.
- Echo latency:
  - Rise detection occurs 2 edges after ECHO is first sampled high (synchronizer).
  - `valid` is registered on the 3rd edge counting the first edge that samples ECHO low. It is high for one cycle, and busy falls in the same cycle.
- Timeout: `timeout` is high in the cycle after the TIMEOUT-th WAIT_RISE cycle.
- `valid`, `timeout` and `overflow` are never high for more than one consecutive cycle. `valid` and `timeout` are never high together.
- Back-to-back: `start` held high re-triggers on the first IDLE cycle after a strobe, so there is one idle cycle between measurements.

## Test plan
- Reset, then `start` for 1 cycle with default parameters. TRIGGER must be high exactly 10 cycles. ECHO is driven high 40 cycles starting 5 cycles after TRIGGER falls. Expect `cantidad`=40, one `valid` pulse 3 edges after ECHO falls, `overflow`=0.
- Echo generator loopback: drive the echo generator with `cantidad`=25, feeding its ECHO into this block. Expect measured `cantidad`=25.
- No echo: `start`, ECHO held 0. Expect `timeout` 255 cycles after TRIGGER falls, previous `cantidad` retained, busy falls.
- Stuck-high echo: ECHO=1 before and throughout; expect `timeout` (no rise). Variant: rise then hold ECHO high 300 cycles; expect `cantidad`=255 with `valid` and `overflow` together.
- `start` pulses during TRIG, WAIT_RISE and MEASURE are ignored, and exactly one `valid` is produced per accepted start. `start` held high produces back-to-back measurements with a 1-cycle IDLE gap.
- `reset` asserted for 1 cycle in the 20th cycle of MEASURE: all outputs are 0 on the next cycle, and a following full measurement of 12 cycles reports 12.
